i2s_adc_rx: RTL and testbench

//  Codec-to-FPGA capture path: deserialises the audio codec's ADC I2S stream (codec is bus master:

---
 rtl/audio_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/i2s_adc_rx.sv | 166 ++++++++++++++++
 tb/tb_i2s_adc_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared types for the codec audio path: I2S channel select,
//                receive FSM states and stereo pair width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

  // Word-select level on the I2S bus: 0 carries left, 1 carries right
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_e;

  // Receive FSM: hunt for a left word start, then alternate left/right
  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_e;

  localparam int CHANNELS = 2;

  // Width of one stereo pair {left, right} for a given per-channel width
  function automatic int pair_width(input int data_width);
    return CHANNELS * data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered count, full/empty flags and
//                simultaneous read/write. A write while full is accepted only
//                if a read happens in the same cycle. The head output holds
//                the last popped value while empty so it never shows X.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA  = 48,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [DATA-1:0] wr_data,
  input  logic            rd_en,
  output logic [DATA-1:0] rd_data,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA-1:0] mem [DEPTH];
  logic [DATA-1:0] last_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            rd_fire, wr_fire;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_fire = rd_en && !empty;
  // Pop is taken first, so a full FIFO can still accept a same-cycle push
  assign wr_fire = wr_en && (!full || rd_fire);
  assign rd_data = empty ? last_q : mem[rd_ptr];

  // Storage array and the copy of the most recently popped head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_q <= '0;
    end else begin
      if (wr_fire) mem[wr_ptr] <= wr_data;
      if (rd_fire) last_q <= mem[rd_ptr];
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_adc_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_adc_rx
//  Description : Codec ADC I2S receiver. Oversamples BCLK/ADCLRCK/ADCDAT on
//                the system clock, deserialises MSB-first words and queues
//                complete {left,right} pairs into a small FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk_50_clk,
  input  logic                  reset_reset_n,
  input  logic                  i2s_bclk,
  input  logic                  i2s_adclrck,
  input  logic                  i2s_adcdat,
  input  logic                  enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = pair_width(DATA_WIDTH);
  localparam logic [CW-1:0] W_CNT = DATA_WIDTH[CW-1:0];

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
  logic                   bclk_prev;
  logic                   bclk_rise, dat_s;
  i2s_ch_e                lrck_now, lrck_last;
  logic                   lr_rise, lr_fall, lr_change;
  logic [DATA_WIDTH-1:0]  shift_q, closed_word, left_word_q;
  logic [CW-1:0]          cnt_q;
  rx_state_e              state_q, state_d;
  logic                   latch_left, close_pair;
  logic                   push_q;
  logic [PW-1:0]          pair_q, head;
  logic                   fifo_full, fifo_empty;
  logic                   drop;

  // All three pad inputs share one synchroniser depth so they stay aligned
  always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_adclrck};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], i2s_adcdat};
      bclk_prev <= bclk_sync[SYNC_STAGES-1];
    end
  end

  assign bclk_rise = bclk_sync[SYNC_STAGES-1] && !bclk_prev;
  assign dat_s     = dat_sync[SYNC_STAGES-1];
  assign lrck_now  = i2s_ch_e'(lrck_sync[SYNC_STAGES-1]);
  assign lr_rise   = bclk_rise && (lrck_last == CH_LEFT)  && (lrck_now == CH_RIGHT);
  assign lr_fall   = bclk_rise && (lrck_last == CH_RIGHT) && (lrck_now == CH_LEFT);
  assign lr_change = lr_rise || lr_fall;

  // Word select as seen at the previous BCLK rise, for change detection
  always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) lrck_last <= CH_LEFT;
    else if (bclk_rise) lrck_last <= lrck_now;
  end

  // Shift register and saturating bit count; the bit at a word-select change is the delay bit
  always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (bclk_rise) begin
      if (lr_change) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (cnt_q < W_CNT) begin
        shift_q <= {shift_q[DATA_WIDTH-2:0], dat_s};
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

  // Short words are left-justified, missing LSBs read as zero
  assign closed_word = shift_q << (W_CNT - cnt_q);

  // FSM state register
  always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= ALIGN;
    else                state_q <= state_d;
  end

  // FSM next state: only a 1->0 word select starts a frame from ALIGN
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ALIGN;
    end else begin
      case (state_q)
        ALIGN:   if (lr_fall) state_d = LEFT;
        LEFT:    if (lr_rise) state_d = RIGHT;
        RIGHT:   if (lr_fall) state_d = LEFT;
        default: state_d = ALIGN;
      endcase
    end
  end

  // FSM outputs: capture left word, complete the pair on the closing edge
  always_comb begin
    latch_left = 1'b0;
    close_pair = 1'b0;
    if (enable) begin
      latch_left = (state_q == LEFT)  && lr_rise;
      close_pair = (state_q == RIGHT) && lr_fall;
    end
  end

  // Hold the left word and stage the completed pair for the FIFO push
  always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      left_word_q <= '0;
      pair_q      <= '0;
      push_q      <= 1'b0;
    end else begin
      push_q <= close_pair;
      if (latch_left) left_word_q <= closed_word;
      if (close_pair) pair_q      <= {left_word_q, closed_word};
    end
  end

  sync_fifo #(
    .DATA  (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_50_clk),
    .rst_n   (reset_reset_n),
    .wr_en   (push_q),
    .wr_data (pair_q),
    .rd_en   (out_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_left  = head[PW-1:DATA_WIDTH];
  assign out_right = head[DATA_WIDTH-1:0];
  assign drop      = push_q && fifo_full && !(out_ready && !fifo_empty);

  // Sticky overflow flag; a new drop beats a simultaneous clear
  always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)    overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_adc_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_adc_rx
//  Description : Directed bench for i2s_adc_rx with a codec-side I2S driver.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_adc_rx;

  localparam int HALF = 163;   // BCLK half period, ~3.07 MHz with 20-unit clk

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bclk = 1'b1, lrck = 1'b1, dat = 1'b0;
  logic        enable = 1'b0, out_ready = 1'b1, overflow_clr = 1'b0;
  logic        out_valid, overflow;
  logic [23:0] out_left, out_right;

  int n_cmp = 0;
  int n_bad = 0;
  logic [47:0] got[$];

  typedef struct {
    logic [31:0] lw;
    logic [31:0] rw;
    int          nbits;
    int          frames;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;
  vec_t vecs[6];

  i2s_adc_rx #(.DATA_WIDTH(24), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk_50_clk    (clk),
    .reset_reset_n (rst_n),
    .i2s_bclk      (bclk),
    .i2s_adclrck   (lrck),
    .i2s_adcdat    (dat),
    .enable        (enable),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_left      (out_left),
    .out_right     (out_right),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  always #10 clk = ~clk;

  // Record every accepted pair
  always @(negedge clk) if (out_valid && out_ready) got.push_back({out_left, out_right});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One BCLK period: codec changes LRCK/DAT on the falling edge
  task automatic bclk_cycle(input logic lr, input logic d);
    bclk = 1'b0; lrck = lr; dat = d;
    #HALF;
    bclk = 1'b1;
    #HALF;
  endtask

  // Delay bit (driven as inverse MSB so a missed discard shows) then n bits MSB first
  task automatic send_half(input logic lr, input logic [31:0] w, input int n);
    bclk_cycle(lr, ~w[n-1]);
    for (int i = n - 1; i >= 0; i--) bclk_cycle(lr, w[i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_half(1'b0, l, n);
    send_half(1'b1, r, n);
  endtask

  task automatic start_stream();
    for (int i = 0; i < 3; i++) bclk_cycle(1'b1, 1'b0);
  endtask

  // Closing 1->0 word select for the last right word, then settle
  task automatic end_stream();
    for (int i = 0; i < 3; i++) bclk_cycle(1'b0, 1'b0);
    repeat (30) @(posedge clk);
  endtask

  // Force the receiver back to ALIGN between streams
  task automatic restart();
    @(posedge clk); #1 enable = 1'b0;
    repeat (4) @(posedge clk);
    #1 enable = 1'b1;
  endtask

  task automatic check_pair(input string name, input int idx, input logic [23:0] el, input logic [23:0] er);
    if (idx < got.size()) begin
      check({name, "_left"},  64'(got[idx][47:24]), 64'(el));
      check({name, "_right"}, 64'(got[idx][23:0]),  64'(er));
    end else begin
      check({name, "_present"}, 64'(got.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{32'h00A5A5A5, 32'h005A5A5A, 24, 3, 24'hA5A5A5, 24'h5A5A5A};
    vecs[1] = '{32'h00001234, 32'h0000BEEF, 16, 1, 24'h123400, 24'hBEEF00};
    vecs[2] = '{32'h89ABCDEF, 32'h01234567, 32, 1, 24'h89ABCD, 24'h012345};
    vecs[3] = '{32'h00800001, 32'h007FFFFE, 24, 2, 24'h800001, 24'h7FFFFE};
    vecs[4] = '{32'h000000A5, 32'h0000003C,  8, 1, 24'hA50000, 24'h3C0000};
    vecs[5] = '{32'h00000001, 32'h00000000,  1, 1, 24'h800000, 24'h000000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_left", 64'(out_left), 64'd0);
    check("rst_right", 64'(out_right), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;

    // Table-driven frames with ready held high
    for (int v = 0; v < 6; v++) begin
      restart();
      got.delete();
      start_stream();
      for (int f = 0; f < vecs[v].frames; f++) send_frame(vecs[v].lw, vecs[v].rw, vecs[v].nbits);
      end_stream();
      check($sformatf("vec%0d_count", v), 64'(got.size()), 64'(vecs[v].frames));
      for (int f = 0; f < vecs[v].frames; f++)
        check_pair($sformatf("vec%0d_p%0d", v, f), f, vecs[v].el, vecs[v].er);
    end

    // Backpressure: six frames into a depth-4 FIFO
    @(posedge clk); #1 out_ready = 1'b0;
    restart();
    got.delete();
    start_stream();
    for (int k = 1; k <= 6; k++) send_frame(32'h100000 + k, 32'h200000 + k, 24);
    end_stream();
    check("ovf_valid", 64'(out_valid), 64'd1);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_head_left", 64'(out_left), 64'h100001);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("ovf_drain_count", 64'(got.size()), 64'd4);
    for (int k = 1; k <= 4; k++)
      check_pair($sformatf("ovf_p%0d", k), k - 1, 24'h100000 + 24'(k), 24'h200000 + 24'(k));
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_empty", 64'(out_valid), 64'd0);
    @(posedge clk); #1 overflow_clr = 1'b1;
    @(posedge clk); #1 overflow_clr = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Stream starting mid-right: the partial right is never pushed
    restart();
    got.delete();
    for (int i = 0; i < 10; i++) bclk_cycle(1'b1, 1'(i));
    send_frame(32'h00C0FFEE, 32'h00123456, 24);
    end_stream();
    check("midright_count", 64'(got.size()), 64'd1);
    check_pair("midright", 0, 24'hC0FFEE, 24'h123456);

    // Enable dropped mid-left: broken frame discarded, next frame intact
    restart();
    got.delete();
    start_stream();
    bclk_cycle(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) bclk_cycle(1'b0, 1'b1);
    @(posedge clk); #1 enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 enable = 1'b1;
    for (int i = 0; i < 12; i++) bclk_cycle(1'b0, 1'b0);
    send_half(1'b1, 32'h00FFFFFF, 24);
    send_frame(32'h00ABCDEF, 32'h00FEDCBA, 24);
    end_stream();
    check("entoggle_count", 64'(got.size()), 64'd1);
    check_pair("entoggle", 0, 24'hABCDEF, 24'hFEDCBA);

    // Push latency from the closing BCLK rise, then reset mid-word
    @(posedge clk); #1 out_ready = 1'b0;
    restart();
    got.delete();
    start_stream();
    send_frame(32'h00DEAD01, 32'h00BEEF02, 24);
    bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
    #HALF;
    bclk = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_within", 64'(lat <= 5), 64'd1);
    #HALF;
    for (int i = 0; i < 8; i++) bclk_cycle(1'b0, 1'b1);
    check("prerst_left", 64'(out_left), 64'hDEAD01);
    #7 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_left", 64'(out_left), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 16; i++) bclk_cycle(1'b0, 1'b1);
    send_half(1'b1, 32'h00777777, 24);
    send_frame(32'h00135790, 32'h00246801, 24);
    end_stream();
    check("postrst_count", 64'(got.size()), 64'd1);
    check_pair("postrst", 0, 24'h135790, 24'h246801);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
